// File: rtl/sd_emmc_raid0_stripe_sched_pkg.sv
// Shared constants for the eMMC RAID0 stripe scheduler: command indices,
// error codes and scheduler state encoding.
package sd_emmc_raid0_stripe_sched_pkg;

   localparam logic [5:0] CMD12 = 6'd12;
   localparam logic [5:0] CMD17 = 6'd17;
   localparam logic [5:0] CMD18 = 6'd18;
   localparam logic [5:0] CMD24 = 6'd24;
   localparam logic [5:0] CMD25 = 6'd25;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_CMD   = 2'd1;
   localparam logic [1:0] ERR_DATA  = 2'd2;
   localparam logic [1:0] ERR_ABORT = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CALC,
      S_CMD,
      S_CMD_WAIT,
      S_BLK,
      S_BLK_WAIT,
      S_STOP,
      S_STOP_WAIT,
      S_ERR,
      S_DONE
   } state_t;

endpackage

// File: rtl/sd_emmc_raid0_stripe_calc.sv
// Combinational RAID0 address split: host LBA/count to per-device
// arguments, block counts, first lane and data command selection.
module sd_emmc_raid0_stripe_calc
   import sd_emmc_raid0_stripe_sched_pkg::*;
(
   input  logic        write_i,
   input  logic [31:0] lba_i,
   input  logic [15:0] blk_cnt_i,
   output logic [31:0] arg0_o,
   output logic [31:0] arg1_o,
   output logic [15:0] n0_o,
   output logic [15:0] n1_o,
   output logic        first_dev_o,
   output logic [5:0]  cmd_index_o,
   output logic [1:0]  cmd_en_o
);

   logic [32:0] lba_inc;
   logic [16:0] sum0;
   logic [16:0] sum1;

   always_comb begin
      lba_inc     = {1'b0, lba_i} + 33'd1;
      arg0_o      = lba_inc[32:1];
      arg1_o      = {1'b0, lba_i[31:1]};
      sum0        = {1'b0, blk_cnt_i} + {16'd0, ~lba_i[0]};
      sum1        = {1'b0, blk_cnt_i} + {16'd0, lba_i[0]};
      n0_o        = sum0[16:1];
      n1_o        = sum1[16:1];
      first_dev_o = lba_i[0];
      if (blk_cnt_i == 16'd1) begin
         cmd_index_o = write_i ? CMD24 : CMD17;
         cmd_en_o    = lba_i[0] ? 2'b10 : 2'b01;
      end else begin
         // multi-block is always issued to both devices, open-ended
         cmd_index_o = write_i ? CMD25 : CMD18;
         cmd_en_o    = 2'b11;
      end
   end

endmodule

// File: rtl/sd_emmc_raid0_stripe_sched.sv
// Schedules one host block transfer across a two-device eMMC RAID0 array:
// issues the data command, walks blocks in host-LBA order, then CMD12.
module sd_emmc_raid0_stripe_sched
   import sd_emmc_raid0_stripe_sched_pkg::*;
#(
   parameter int unsigned CMD_TIMEOUT = 1024,
   parameter int unsigned BLK_TIMEOUT = 65535
)
(
   input  logic        sd_clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        write_i,
   input  logic [31:0] lba_i,
   input  logic [15:0] blk_cnt_i,
   input  logic        abort_i,
   output logic        cmd_start_o,
   output logic [1:0]  cmd_en_o,
   output logic [5:0]  cmd_index_o,
   output logic [31:0] cmd_arg0_o,
   output logic [31:0] cmd_arg1_o,
   input  logic        cmd_done_i,
   input  logic        cmd_err_i,
   output logic        blk_start_o,
   output logic        blk_dev_o,
   input  logic        blk_done_i,
   input  logic        blk_err_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [1:0]  err_o
);

   localparam logic [15:0] CMD_TMO_LAST = 16'(CMD_TIMEOUT - 1);
   localparam logic [15:0] BLK_TMO_LAST = 16'(BLK_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        write_q;
   logic [31:0] lba_q;
   logic [15:0] cnt_q;
   logic [31:0] arg0_q, arg1_q;
   logic [5:0]  idx_q;
   logic [1:0]  en_q;
   logic [15:0] rem0_q, rem1_q;
   logic        dev_q;
   logic        acc_q;
   logic [1:0]  err_q;
   logic [15:0] wd_q;

   logic [31:0] c_arg0, c_arg1;
   logic [15:0] c_n0, c_n1;
   logic        c_first;
   logic [5:0]  c_idx;
   logic [1:0]  c_en;

   logic        multi, last_blk, cmd_tmo, blk_tmo;
   logic        latch_start, mark_acc, blk_adv, set_err;
   logic [1:0]  err_code;

   sd_emmc_raid0_stripe_calc u_calc (
      .write_i     (write_q),
      .lba_i       (lba_q),
      .blk_cnt_i   (cnt_q),
      .arg0_o      (c_arg0),
      .arg1_o      (c_arg1),
      .n0_o        (c_n0),
      .n1_o        (c_n1),
      .first_dev_o (c_first),
      .cmd_index_o (c_idx),
      .cmd_en_o    (c_en)
   );

   assign multi    = cnt_q > 16'd1;
   assign cmd_tmo  = wd_q == CMD_TMO_LAST;
   assign blk_tmo  = wd_q == BLK_TMO_LAST;
   assign last_blk = dev_q ? (rem1_q == 16'd1 && rem0_q == '0)
                           : (rem0_q == 16'd1 && rem1_q == '0);

   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      latch_start = 1'b0;
      mark_acc    = 1'b0;
      blk_adv     = 1'b0;
      set_err     = 1'b0;
      err_code    = ERR_NONE;
      cmd_start_o = 1'b0;
      blk_start_o = 1'b0;
      done_o      = 1'b0;
      busy_o      = state_q != S_IDLE;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               latch_start = 1'b1;
               state_d     = S_CALC;
            end
         end
         S_CALC: state_d = (cnt_q == '0) ? S_DONE : S_CMD;
         S_CMD: begin
            cmd_start_o = 1'b1;
            state_d     = S_CMD_WAIT;
         end
         S_CMD_WAIT: begin
            if (cmd_done_i) begin
               if (cmd_err_i) begin
                  set_err  = 1'b1;
                  err_code = ERR_CMD;
                  state_d  = S_ERR;
               end else begin
                  mark_acc = 1'b1;
                  state_d  = S_BLK;
               end
            end else if (cmd_tmo) begin
               set_err  = 1'b1;
               err_code = ERR_CMD;
               state_d  = S_ERR;
            end
            if (abort_i && !(cmd_done_i && cmd_err_i)) begin
               set_err  = 1'b1;
               err_code = ERR_ABORT;
               state_d  = multi ? S_STOP : S_DONE;
            end
         end
         S_BLK: begin
            blk_start_o = 1'b1;
            state_d     = S_BLK_WAIT;
            if (abort_i) begin
               set_err  = 1'b1;
               err_code = ERR_ABORT;
               state_d  = multi ? S_STOP : S_DONE;
            end
         end
         S_BLK_WAIT: begin
            // completion beats a coincident timeout; a completed block is
            // still counted when abort arrives in the same cycle
            if (blk_done_i) begin
               if (blk_err_i) begin
                  set_err  = 1'b1;
                  err_code = ERR_DATA;
                  state_d  = S_ERR;
               end else begin
                  blk_adv = 1'b1;
                  if (last_blk) state_d = multi ? S_STOP : S_DONE;
                  else          state_d = S_BLK;
               end
            end else if (blk_tmo) begin
               set_err  = 1'b1;
               err_code = ERR_DATA;
               state_d  = S_ERR;
            end
            if (abort_i && !(blk_done_i && blk_err_i)) begin
               set_err  = 1'b1;
               err_code = ERR_ABORT;
               state_d  = multi ? S_STOP : S_DONE;
            end
         end
         S_STOP: begin
            cmd_start_o = 1'b1;
            state_d     = S_STOP_WAIT;
         end
         S_STOP_WAIT: begin
            if (cmd_done_i || cmd_tmo) begin
               if ((cmd_tmo || cmd_err_i) && err_q == ERR_NONE) begin
                  set_err  = 1'b1;
                  err_code = ERR_CMD;
               end
               state_d = S_DONE;
            end
         end
         S_ERR:  state_d = (multi && acc_q) ? S_STOP : S_DONE;
         S_DONE: begin
            done_o  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sd_clk or posedge rst) begin
      if (rst) begin
         write_q <= 1'b0;
         lba_q   <= '0;
         cnt_q   <= '0;
         arg0_q  <= '0;
         arg1_q  <= '0;
         idx_q   <= '0;
         en_q    <= '0;
         rem0_q  <= '0;
         rem1_q  <= '0;
         dev_q   <= 1'b0;
         acc_q   <= 1'b0;
         err_q   <= ERR_NONE;
         wd_q    <= '0;
      end else begin
         if (latch_start) begin
            write_q <= write_i;
            lba_q   <= lba_i;
            cnt_q   <= blk_cnt_i;
            err_q   <= ERR_NONE;
            acc_q   <= 1'b0;
         end
         if (state_q == S_CALC) begin
            arg0_q <= c_arg0;
            arg1_q <= c_arg1;
            idx_q  <= c_idx;
            en_q   <= c_en;
            rem0_q <= c_n0;
            rem1_q <= c_n1;
            dev_q  <= c_first;
         end
         if (state_d == S_STOP && state_q != S_STOP) begin
            idx_q  <= CMD12;
            en_q   <= 2'b11;
            arg0_q <= '0;
            arg1_q <= '0;
         end
         if (mark_acc) acc_q <= 1'b1;
         if (blk_adv) begin
            dev_q <= ~dev_q;
            if (dev_q) rem1_q <= rem1_q - 16'd1;
            else       rem0_q <= rem0_q - 16'd1;
         end
         if (set_err) err_q <= err_code;
         wd_q <= (state_d != state_q) ? '0 : wd_q + 16'd1;
      end
   end

   assign cmd_en_o    = en_q;
   assign cmd_index_o = idx_q;
   assign cmd_arg0_o  = arg0_q;
   assign cmd_arg1_o  = arg1_q;
   assign blk_dev_o   = dev_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_sd_emmc_raid0_stripe_sched.sv
// Directed bench for the RAID0 stripe scheduler: bench-side command/data
// responders, a transaction-level expectation model and a per-cycle checker.
module tb_sd_emmc_raid0_stripe_sched;

   logic        sd_clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0, write_i = 1'b0, abort_i = 1'b0;
   logic [31:0] lba_i = '0;
   logic [15:0] blk_cnt_i = '0;
   logic        cmd_done_i = 1'b0, cmd_err_i = 1'b0;
   logic        blk_done_i = 1'b0, blk_err_i = 1'b0;
   logic        cmd_start_o, blk_start_o, blk_dev_o, busy_o, done_o;
   logic [1:0]  cmd_en_o, err_o;
   logic [5:0]  cmd_index_o;
   logic [31:0] cmd_arg0_o, cmd_arg1_o;

   sd_emmc_raid0_stripe_sched #(.CMD_TIMEOUT(64), .BLK_TIMEOUT(16)) dut (
      .sd_clk(sd_clk), .rst(rst), .start_i(start_i), .write_i(write_i),
      .lba_i(lba_i), .blk_cnt_i(blk_cnt_i), .abort_i(abort_i),
      .cmd_start_o(cmd_start_o), .cmd_en_o(cmd_en_o), .cmd_index_o(cmd_index_o),
      .cmd_arg0_o(cmd_arg0_o), .cmd_arg1_o(cmd_arg1_o),
      .cmd_done_i(cmd_done_i), .cmd_err_i(cmd_err_i),
      .blk_start_o(blk_start_o), .blk_dev_o(blk_dev_o),
      .blk_done_i(blk_done_i), .blk_err_i(blk_err_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 sd_clk = ~sd_clk;

   typedef struct packed {
      logic [5:0]  idx;
      logic [1:0]  en;
      logic [31:0] a0;
      logic [31:0] a1;
   } cmd_t;

   cmd_t        exp_cmd_q[$];
   bit          exp_dev_q[$];
   logic [1:0]  exp_err;
   int          checks = 0, errors = 0;
   int          cyc = 0, done_cnt = 0, done_cyc = 0, start_cyc = 0;
   int          cmd_cnt = 0, first_cmd_cyc = 0, blk_cnt_seen = 0;
   cmd_t        first_cmd, last_cmd;
   logic [15:0] dev_bits;

   int          cmd_wait = 0, blk_wait = 0, blk_started = 0;
   int          hold_blk = -1, abort_blk = -1;
   bit          inj_cmd_err = 0, abort_pend = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // kind doubles as the expected error code: 0 clean, 1 command error,
   // 2 data timeout on block stop_blk, 3 abort during block stop_blk
   function automatic void build_model(input bit wr, input logic [31:0] l, input int n,
                                       input int kind, input int stop_blk);
      cmd_t c;
      int   nblk;
      exp_cmd_q.delete();
      exp_dev_q.delete();
      exp_err = 2'(kind);
      if (n == 0) return;
      c.a0 = 32'((64'(l) + 64'd1) / 64'd2);
      c.a1 = 32'(64'(l) / 64'd2);
      if (n == 1) begin
         c.idx = wr ? 6'd24 : 6'd17;
         c.en  = (64'(l) % 64'd2 == 64'd1) ? 2'b10 : 2'b01;
      end else begin
         c.idx = wr ? 6'd25 : 6'd18;
         c.en  = 2'b11;
      end
      exp_cmd_q.push_back(c);
      nblk = (kind == 0) ? n : ((kind == 1) ? 0 : stop_blk + 1);
      for (int k = 0; k < nblk; k++)
         exp_dev_q.push_back(bit'((64'(l) + 64'(k)) % 64'd2));
      if (n >= 2 && kind != 1) begin
         c.idx = 6'd12; c.en = 2'b11; c.a0 = '0; c.a1 = '0;
         exp_cmd_q.push_back(c);
      end
   endfunction

   // command and data layer responders
   always @(negedge sd_clk) begin
      cmd_done_i = 1'b0; cmd_err_i = 1'b0;
      blk_done_i = 1'b0; blk_err_i = 1'b0;
      abort_i    = abort_pend;
      abort_pend = 0;
      if (cmd_wait > 0) begin
         cmd_wait--;
         if (cmd_wait == 0) begin
            cmd_done_i  = 1'b1;
            cmd_err_i   = inj_cmd_err;
            inj_cmd_err = 0;
         end
      end
      if (cmd_start_o) cmd_wait = 3;
      if (blk_wait > 0) begin
         blk_wait--;
         if (blk_wait == 0) blk_done_i = 1'b1;
      end
      if (blk_start_o) begin
         if (blk_started != hold_blk) blk_wait = 2;
         if (blk_started == abort_blk) abort_pend = 1;
         blk_started++;
      end
   end

   // per-cycle checker against the model
   initial forever begin
      cmd_t c;
      @(posedge sd_clk);
      #1;
      cyc++;
      if (!rst) begin
         if (cmd_start_o) begin
            check("busy_during_cmd", 64'(busy_o), 64'd1);
            if (cmd_cnt == 0) begin first_cmd_cyc = cyc; first_cmd = {cmd_index_o, cmd_en_o, cmd_arg0_o, cmd_arg1_o}; end
            last_cmd = {cmd_index_o, cmd_en_o, cmd_arg0_o, cmd_arg1_o};
            cmd_cnt++;
            if (exp_cmd_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_cmd: got index %0d, expected no command", cmd_index_o);
            end else begin
               c = exp_cmd_q.pop_front();
               check("cmd_index", 64'(cmd_index_o), 64'(c.idx));
               check("cmd_en",    64'(cmd_en_o),    64'(c.en));
               check("cmd_arg0",  64'(cmd_arg0_o),  64'(c.a0));
               check("cmd_arg1",  64'(cmd_arg1_o),  64'(c.a1));
            end
         end
         if (blk_start_o) begin
            if (blk_cnt_seen < 16) dev_bits[blk_cnt_seen] = blk_dev_o;
            blk_cnt_seen++;
            if (exp_dev_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_blk: got dev %0d, expected no block", blk_dev_o);
            end else
               check("blk_dev", 64'(blk_dev_o), 64'(exp_dev_q.pop_front()));
         end
         if (done_o) begin
            check("err_at_done", 64'(err_o), 64'(exp_err));
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic run_xfer(input bit wr, input logic [31:0] l, input int n,
                           input int kind, input int stop_blk);
      int d0;
      build_model(wr, l, n, kind, stop_blk);
      inj_cmd_err  = (kind == 1);
      hold_blk     = (kind == 2) ? stop_blk : -1;
      abort_blk    = (kind == 3) ? stop_blk : -1;
      blk_started  = 0;
      cmd_cnt      = 0;
      blk_cnt_seen = 0;
      dev_bits     = '0;
      d0           = done_cnt;
      @(negedge sd_clk);
      start_i = 1'b1; write_i = wr; lba_i = l; blk_cnt_i = 16'(n);
      start_cyc = cyc;
      @(negedge sd_clk);
      start_i = 1'b0;
      for (int i = 0; i < 3000 && done_cnt == d0; i++) @(negedge sd_clk);
      check("done_reached", 64'(done_cnt - d0), 64'd1);
      check("cmds_left", 64'(exp_cmd_q.size()), 64'd0);
      check("blks_left", 64'(exp_dev_q.size()), 64'd0);
      repeat (4) @(negedge sd_clk);
      check("idle_after", 64'(busy_o), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge sd_clk);
      check("reset_outputs",
            {cmd_start_o, cmd_en_o, cmd_index_o, cmd_arg0_o, cmd_arg1_o[15:0],
             blk_start_o, blk_dev_o, busy_o, done_o, err_o},
            64'd0);
      rst = 1'b0;
      repeat (2) @(negedge sd_clk);

      run_xfer(1'b0, 32'd7, 1, 0, 0);
      check("t1_index", 64'(first_cmd.idx), 64'd17);
      check("t1_en", 64'(first_cmd.en), 64'd2);
      check("t1_arg1", 64'(first_cmd.a1), 64'd3);
      check("t1_cmd_count", 64'(cmd_cnt), 64'd1);
      check("t1_blk_count", 64'(blk_cnt_seen), 64'd1);
      check("t1_blk_dev", 64'(dev_bits[0]), 64'd1);
      check("t1_cmd_latency", 64'(first_cmd_cyc - start_cyc), 64'd2);

      run_xfer(1'b1, 32'd0, 4, 0, 0);
      check("t2_index", 64'(first_cmd.idx), 64'd25);
      check("t2_en", 64'(first_cmd.en), 64'd3);
      check("t2_args", {first_cmd.a0, first_cmd.a1}, 64'd0);
      check("t2_dev_seq", 64'(dev_bits[3:0]), 64'b1010);
      check("t2_stop_index", 64'(last_cmd.idx), 64'd12);
      check("t2_cmd_count", 64'(cmd_cnt), 64'd2);

      run_xfer(1'b0, 32'd5, 3, 0, 0);
      check("t3_index", 64'(first_cmd.idx), 64'd18);
      check("t3_arg0", 64'(first_cmd.a0), 64'd3);
      check("t3_arg1", 64'(first_cmd.a1), 64'd2);
      check("t3_dev_seq", 64'(dev_bits[2:0]), 64'b101);
      check("t3_stop_index", 64'(last_cmd.idx), 64'd12);

      run_xfer(1'b0, 32'd10, 4, 1, 0);
      check("t4_no_blk", 64'(blk_cnt_seen), 64'd0);
      check("t4_cmd_count", 64'(cmd_cnt), 64'd1);
      check("t4_err", 64'(err_o), 64'd1);

      run_xfer(1'b1, 32'd20, 4, 2, 1);
      check("t5_stop_index", 64'(last_cmd.idx), 64'd12);
      check("t5_blk_count", 64'(blk_cnt_seen), 64'd2);
      check("t5_err", 64'(err_o), 64'd2);

      run_xfer(1'b0, 32'd3, 6, 3, 1);
      check("t6_stop_index", 64'(last_cmd.idx), 64'd12);
      check("t6_blk_count", 64'(blk_cnt_seen), 64'd2);
      repeat (5) @(negedge sd_clk);
      check("t6_err_held", 64'(err_o), 64'd3);

      run_xfer(1'b0, 32'd100, 0, 0, 0);
      check("t7_done_latency", 64'(done_cyc - start_cyc), 64'd2);
      check("t7_no_cmd", 64'(cmd_cnt), 64'd0);
      check("t7_err", 64'(err_o), 64'd0);

      run_xfer(1'b1, 32'hFFFF_FFFF, 2, 0, 0);
      check("t8_arg0_wrap", 64'(first_cmd.a0), 64'h8000_0000);
      check("t8_arg1", 64'(first_cmd.a1), 64'h7FFF_FFFF);
      check("t8_dev_seq", 64'(dev_bits[1:0]), 64'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sd_emmc_raid0_stripe_sched.md
Name: sd_emmc_raid0_stripe_sched

Overview:
- Schedules one host block transfer across the two-device eMMC RAID0 array.
- Even LBAs map to device 0 and odd LBAs to device 1; device LBA = host LBA >> 1.
- Computes per-device start address and block counts, then issues the data command (plus CMD12 stop) through the shared dual-device command layer.
- Sequences the per-block data lane between devices in host-LBA order. Sits between the host register/DMA front end and the command/data layers.

Parameters:
- CMD_TIMEOUT, 1024, sd_clk cycles allowed from cmd_start_o to cmd_done_i.
- BLK_TIMEOUT, 65535, sd_clk cycles allowed from blk_start_o to blk_done_i.

Ports:
- sd_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  transfer request; sampled only in S_IDLE.
- write_i  in  1  1 = write (CMD24/25), 0 = read (CMD17/18); latched with start_i.
- lba_i  in  32  host start LBA; latched with start_i.
- blk_cnt_i  in  16  host block count N; latched with start_i.
- abort_i  in  1  abort request, any state.
- cmd_start_o  out  1  one-cycle pulse to the command layer.
- cmd_en_o  out  2  per-device enable for the issued command; bit0 = device 0.
- cmd_index_o  out  6  command index.
- cmd_arg0_o  out  32  device-0 argument.
- cmd_arg1_o  out  32  device-1 argument.
- cmd_done_i  in  1  all enabled devices finished the command.
- cmd_err_i  in  1  CRC, index or timeout error, valid with cmd_done_i.
- blk_start_o  out  1  one-cycle pulse: move one 512 B block on lane blk_dev_o.
- blk_dev_o  out  1  device lane for the current block.
- blk_done_i  in  1  block moved.
- blk_err_i  in  1  data CRC error, valid with blk_done_i.
- busy_o  out  1  high whenever state != S_IDLE.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  2  0 ok, 1 cmd error, 2 data error/timeout, 3 aborted; held until next accepted start.

Behaviour:
- Reset: all outputs 0; state S_IDLE.
- Address split, with L = latched lba_i:
  - arg0 = (L+1)>>1 and arg1 = L>>1, computed 33-bit, truncated to 32.
  - N0 = (N + !L[0]) >> 1; N1 = (N + L[0]) >> 1. 17-bit add, no overflow.
- Command choice:
  - N == 1: single-block command (CMD17/CMD24); cmd_en_o = only the device owning L.
  - N >= 2: CMD18/CMD25 to both devices (cmd_en_o = 2'b11), open-ended, even if one device gets a single block.
- States and transitions:
  - S_IDLE: on start_i, latch inputs and clear err_o → S_CALC.
  - S_CALC: register args, counts and index. If N == 0 → S_DONE with err 0, no command issued. Otherwise → S_CMD.
  - S_CMD: assert cmd_start_o for exactly 1 cycle → S_CMD_WAIT. cmd_start_o therefore pulses 2 cycles after start_i is sampled.
  - S_CMD_WAIT: on cmd_done_i, go to S_ERR (err 1) if cmd_err_i, else S_BLK. Watchdog reaching CMD_TIMEOUT → S_ERR (err 1).
  - S_BLK: 1-cycle blk_start_o pulse with blk_dev_o = current device; first device = L[0] → S_BLK_WAIT.
  - S_BLK_WAIT: on blk_done_i, go to S_ERR (err 2) if blk_err_i. Otherwise toggle device, decrement remaining count; if remaining = 0 → S_STOP (N >= 2) or S_DONE (N == 1), else → S_BLK. Watchdog reaching BLK_TIMEOUT → S_ERR (err 2).
  - S_STOP: cmd_start_o pulse, index 12, arg 0, cmd_en_o = 2'b11 → S_STOP_WAIT.
  - S_STOP_WAIT: cmd_done_i → S_DONE. An error here sets err 1 but still → S_DONE.
  - S_ERR: if N >= 2 and a data command was accepted, issue CMD12 (via S_STOP) to recover devices, then S_DONE keeps the error code. Otherwise → S_DONE.
  - S_DONE: done_o = 1 for one cycle → S_IDLE.
- Watchdogs: 16-bit counter, cleared on entry to each wait state.
- abort_i:
  - In S_IDLE/S_CALC: no effect.
  - In S_CMD_WAIT, S_BLK or S_BLK_WAIT: err 3, then CMD12 flow (N >= 2) or S_DONE.
  - In S_STOP, S_STOP_WAIT, S_ERR or S_DONE: ignored.
- Simultaneous events:
  - blk_done_i and a timeout in the same cycle: done wins.
  - abort_i and blk_done_i in the same cycle: the block is counted, then abort is taken.
- start_i outside S_IDLE: ignored, no queueing.
- Async rst mid-transfer returns to S_IDLE immediately; no stop command is issued.

Decomposition:
- Shared header sd_emmc_defines.h gains:
  - CMD12/17/18/24/25 index constants;
  - err code constants (ERR_NONE, ERR_CMD, ERR_DATA, ERR_ABORT);
  - state encodings.
- One sub-module: sd_emmc_raid0_stripe_calc. It is combinational: L, N → arg0, arg1, N0, N1, first_dev, cmd_index, cmd_en. It is instantiated once and registered in S_CALC.

Test Plan:
- Read, L=7, N=1 → cmd_index 17, cmd_en 2'b10, arg1=3; one blk_start on dev1; no CMD12; done_o with err 0.
- Write, L=0, N=4 → index 25, en 2'b11, arg0=0, arg1=0; blk_dev sequence 0,1,0,1; then CMD12; done err 0.
- Read, L=5, N=3 → index 18, arg0=3, arg1=2; blk_dev sequence 1,0,1; CMD12; done.
- cmd_err_i with the first cmd_done_i (N=4) → no blk_start; done_o with err 1.
- blk_done_i withheld on block 2 of N=4 for BLK_TIMEOUT (set to 16 in the bench) → CMD12 issued; err 2.
- abort_i while in S_BLK_WAIT on block 2 of N=6 → CMD12 issued; done err 3. Then start with N=0 → done_o 2 cycles after start, no cmd_start_o, err 0.
